banked_memory: RTL and testbench

- Parametrised successor to the two-bank main memory. Holds NUM_BANKS independent banks of BANK_DEPTH words each.
- Global address layout is {bank_sel, local_addr}. Writes are decoded to exactly one bank; reads are muxed from the addressed bank.
- Adds registered read with a valid/ready handshake, per-word written flags, write-first bypass, and a background clear sweep controlled by a small FSM.
- Sits between the datapath and the controller as the main data store.

---
 rtl/banked_memory_pkg.sv | 25 ++
 rtl/banked_memory_mem_bank.sv | 47 ++++
 rtl/banked_memory.sv | 134 +++++++++++++
 tb/tb_banked_memory.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/banked_memory_pkg.sv
// Shared types, default widths and address-split helpers for the banked main memory.
package banked_memory_pkg;

    localparam int unsigned DEF_DATA_WIDTH      = 64;
    localparam int unsigned DEF_BANK_ADDR_WIDTH = 3;
    localparam int unsigned DEF_NUM_BANKS       = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        DONE  = 2'd2
    } state_t;

    // Global address is {bank_sel, local_addr}
    function automatic int unsigned bank_of(input int unsigned addr,
                                            input int unsigned bank_addr_width);
        return addr >> bank_addr_width;
    endfunction

    function automatic int unsigned local_of(input int unsigned addr,
                                             input int unsigned bank_addr_width);
        return addr & ((32'd1 << bank_addr_width) - 32'd1);
    endfunction

endpackage

// File: rtl/banked_memory_mem_bank.sv
// One storage bank: single write port, combinational read port, per-word written flags.
module mem_bank
    import banked_memory_pkg::*;
#(
    parameter int unsigned DATA_WIDTH      = DEF_DATA_WIDTH,
    parameter int unsigned BANK_ADDR_WIDTH = DEF_BANK_ADDR_WIDTH
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       wr_en,
    input  logic [BANK_ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0]      wr_data,
    input  logic                       clr_en,
    input  logic [BANK_ADDR_WIDTH-1:0] clr_addr,
    input  logic [BANK_ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0]      rd_data_c,
    output logic                       rd_written_c
);

    localparam int unsigned BANK_DEPTH = 1 << BANK_ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem [BANK_DEPTH];
    logic [BANK_DEPTH-1:0] written;

    // Array has no reset; the written flags decide whether contents are meaningful
    always_ff @(posedge clk) begin
        if (clr_en) begin
            mem[clr_addr] <= '0;
        end else if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            written <= '0;
        end else if (clr_en) begin
            written[clr_addr] <= 1'b0;
        end else if (wr_en) begin
            written[wr_addr] <= 1'b1;
        end
    end

    assign rd_data_c    = mem[rd_addr];
    assign rd_written_c = written[rd_addr];

endmodule

// File: rtl/banked_memory.sv
// Banked main data store: decoded writes, registered handshaked reads with write-first
// bypass, and a background clear sweep.
module banked_memory
    import banked_memory_pkg::*;
#(
    parameter int unsigned DATA_WIDTH      = DEF_DATA_WIDTH,
    parameter int unsigned BANK_ADDR_WIDTH = DEF_BANK_ADDR_WIDTH,
    parameter int unsigned NUM_BANKS       = DEF_NUM_BANKS,
    parameter int unsigned BANK_SEL_WIDTH  = $clog2(NUM_BANKS),
    parameter int unsigned ADDR_WIDTH      = BANK_SEL_WIDTH + BANK_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    input  logic                  rd_ready,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_valid,
    output logic                  rd_uninit,
    input  logic                  clear_req,
    output logic                  busy
);

    localparam int unsigned BANK_DEPTH = 1 << BANK_ADDR_WIDTH;

    state_t                     state, state_next;
    logic [BANK_ADDR_WIDTH-1:0] cnt, cnt_next;
    logic                       busy_next;
    logic                       clr_en;

    logic [BANK_SEL_WIDTH-1:0]  wr_bank, rd_bank;
    logic [BANK_ADDR_WIDTH-1:0] wr_local, rd_local;
    logic                       wr_acc, rd_acc;

    logic [DATA_WIDTH-1:0]      bank_rd_data [NUM_BANKS];
    logic [NUM_BANKS-1:0]       bank_written;
    logic [DATA_WIDTH-1:0]      rd_word;
    logic                       rd_unw;

    assign wr_bank  = BANK_SEL_WIDTH'(bank_of(32'(wr_addr), BANK_ADDR_WIDTH));
    assign rd_bank  = BANK_SEL_WIDTH'(bank_of(32'(rd_addr), BANK_ADDR_WIDTH));
    assign wr_local = BANK_ADDR_WIDTH'(local_of(32'(wr_addr), BANK_ADDR_WIDTH));
    assign rd_local = BANK_ADDR_WIDTH'(local_of(32'(rd_addr), BANK_ADDR_WIDTH));

    assign wr_acc = wr_en && !busy;
    assign rd_acc = rd_en && !busy && (!rd_valid || rd_ready);

    // Clear sweep state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
            busy  <= 1'b0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            busy  <= busy_next;
        end
    end

    // Sweep walks one local row per cycle across every bank, then spends one cycle in DONE
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        clr_en     = 1'b0;
        case (state)
            IDLE: begin
                if (clear_req) begin
                    state_next = CLEAR;
                    cnt_next   = '0;
                end
            end
            CLEAR: begin
                clr_en   = 1'b1;
                cnt_next = cnt + BANK_ADDR_WIDTH'(1);
                if (cnt == BANK_ADDR_WIDTH'(BANK_DEPTH - 1)) begin
                    state_next = DONE;
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
        busy_next = (state_next != IDLE);
    end

    for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
        mem_bank #(
            .DATA_WIDTH     (DATA_WIDTH),
            .BANK_ADDR_WIDTH(BANK_ADDR_WIDTH)
        ) u_bank (
            .clk         (clk),
            .rst_n       (rst_n),
            .wr_en       (wr_acc && (wr_bank == BANK_SEL_WIDTH'(b))),
            .wr_addr     (wr_local),
            .wr_data     (wr_data),
            .clr_en      (clr_en),
            .clr_addr    (cnt),
            .rd_addr     (rd_local),
            .rd_data_c   (bank_rd_data[b]),
            .rd_written_c(bank_written[b])
        );
    end

    // Read mux with write-first bypass on an exact global address match
    always_comb begin
        rd_word = '0;
        rd_unw  = 1'b1;
        if (wr_acc && (wr_addr == rd_addr)) begin
            rd_word = wr_data;
            rd_unw  = 1'b0;
        end else if (bank_written[rd_bank]) begin
            rd_word = bank_rd_data[rd_bank];
            rd_unw  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data   <= '0;
            rd_valid  <= 1'b0;
            rd_uninit <= 1'b0;
        end else if (rd_acc) begin
            rd_data   <= rd_word;
            rd_valid  <= 1'b1;
            rd_uninit <= rd_unw;
        end else if (rd_valid && rd_ready) begin
            rd_valid  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_banked_memory.sv
// Directed self-checking bench for banked_memory: default 2x8 config plus a 4x4 instance.
module tb_banked_memory;

    logic        clk;
    logic        rst_n, rst_n4;

    logic        wr_en, rd_en, rd_ready, clear_req;
    logic [3:0]  wr_addr, rd_addr;
    logic [63:0] wr_data;
    logic [63:0] rd_data;
    logic        rd_valid, rd_uninit, busy;

    logic        wr_en4, rd_en4, rd_ready4, clear_req4;
    logic [3:0]  wr_addr4, rd_addr4;
    logic [63:0] wr_data4;
    logic [63:0] rd_data4;
    logic        rd_valid4, rd_uninit4, busy4;

    int checks   = 0;
    int failures = 0;
    int n;
    logic saw_valid;

    banked_memory dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .rd_en    (rd_en),
        .rd_addr  (rd_addr),
        .rd_ready (rd_ready),
        .rd_data  (rd_data),
        .rd_valid (rd_valid),
        .rd_uninit(rd_uninit),
        .clear_req(clear_req),
        .busy     (busy)
    );

    banked_memory #(
        .DATA_WIDTH     (64),
        .BANK_ADDR_WIDTH(2),
        .NUM_BANKS      (4)
    ) dut4 (
        .clk      (clk),
        .rst_n    (rst_n4),
        .wr_en    (wr_en4),
        .wr_addr  (wr_addr4),
        .wr_data  (wr_data4),
        .rd_en    (rd_en4),
        .rd_addr  (rd_addr4),
        .rd_ready (rd_ready4),
        .rd_data  (rd_data4),
        .rd_valid (rd_valid4),
        .rd_uninit(rd_uninit4),
        .clear_req(clear_req4),
        .busy     (busy4)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; rst_n4 = 1'b0;
        wr_en = 1'b0; rd_en = 1'b0; rd_ready = 1'b1; clear_req = 1'b0;
        wr_addr = '0; rd_addr = '0; wr_data = '0;
        wr_en4 = 1'b0; rd_en4 = 1'b0; rd_ready4 = 1'b1; clear_req4 = 1'b0;
        wr_addr4 = '0; rd_addr4 = '0; wr_data4 = '0;
        #12;
        chk("reset_rd_data", rd_data, 64'h0);
        chk("reset_rd_valid", 64'(rd_valid), 64'h0);
        chk("reset_rd_uninit", 64'(rd_uninit), 64'h0);
        chk("reset_busy", 64'(busy), 64'h0);
        rst_n = 1'b1; rst_n4 = 1'b1;
        tick();

        // Unwritten word after reset
        rd_en = 1'b1; rd_addr = 4'h5;
        tick();
        chk("uninit_valid", 64'(rd_valid), 64'h1);
        chk("uninit_data", rd_data, 64'h0);
        chk("uninit_flag", 64'(rd_uninit), 64'h1);
        rd_en = 1'b0;
        tick();
        chk("uninit_drain", 64'(rd_valid), 64'h0);

        // Writes to both banks, then back-to-back reads
        wr_en = 1'b1; wr_addr = 4'h3; wr_data = 64'hA5A5_0000_0000_0001;
        tick();
        wr_addr = 4'hB; wr_data = 64'hDEAD_BEEF_0000_0002;
        tick();
        wr_en = 1'b0;
        rd_en = 1'b1; rd_addr = 4'h3;
        tick();
        chk("b0_data", rd_data, 64'hA5A5_0000_0000_0001);
        chk("b0_uninit", 64'(rd_uninit), 64'h0);
        rd_addr = 4'hB;
        tick();
        chk("b1_data", rd_data, 64'hDEAD_BEEF_0000_0002);
        chk("b1_valid", 64'(rd_valid), 64'h1);
        chk("b1_uninit", 64'(rd_uninit), 64'h0);
        rd_en = 1'b0;
        tick();
        chk("b2b_drain", 64'(rd_valid), 64'h0);

        // Write-first bypass on same address
        wr_en = 1'b1; wr_addr = 4'h6; wr_data = 64'h1234;
        rd_en = 1'b1; rd_addr = 4'h6;
        tick();
        chk("bypass_data", rd_data, 64'h1234);
        chk("bypass_uninit", 64'(rd_uninit), 64'h0);
        wr_en = 1'b0; rd_en = 1'b0;
        tick();

        // Output stall holds the word while rd_addr changes
        rd_ready = 1'b0; rd_en = 1'b1; rd_addr = 4'h3;
        tick();
        chk("stall_first", rd_data, 64'hA5A5_0000_0000_0001);
        rd_addr = 4'hB;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("stall_hold_data", rd_data, 64'hA5A5_0000_0000_0001);
            chk("stall_hold_valid", 64'(rd_valid), 64'h1);
        end
        rd_ready = 1'b1;
        tick();
        chk("stall_release", rd_data, 64'hDEAD_BEEF_0000_0002);
        rd_en = 1'b0;
        tick();

        // Fill all 16 words then sweep
        wr_en = 1'b1;
        for (int i = 0; i < 16; i++) begin
            wr_addr = 4'(i); wr_data = 64'h1000 + 64'(i);
            tick();
        end
        wr_en = 1'b0;
        clear_req = 1'b1; rd_en = 1'b1; rd_addr = 4'h5;
        tick();
        chk("preclear_read", rd_data, 64'h1005);
        chk("preclear_uninit", 64'(rd_uninit), 64'h0);
        clear_req = 1'b0;
        n = 0; saw_valid = 1'b0;
        while (busy && n < 20) begin
            if (n > 0) saw_valid = saw_valid | rd_valid;
            n++;
            wr_en = 1'b1; wr_addr = 4'h2; wr_data = 64'hFFFF;
            rd_en = 1'b1; rd_addr = 4'h2;
            tick();
        end
        wr_en = 1'b0; rd_en = 1'b0;
        chk("busy_cycles", 64'(n), 64'd9);
        chk("busy_read_ignored", 64'(saw_valid), 64'h0);
        chk("busy_end_valid", 64'(rd_valid), 64'h0);
        rd_en = 1'b1;
        for (int i = 0; i < 16; i++) begin
            rd_addr = 4'(i);
            tick();
            chk("cleared_data", rd_data, 64'h0);
            chk("cleared_uninit", 64'(rd_uninit), 64'h1);
        end
        rd_en = 1'b0;
        tick();

        // 4-bank instance: reset in the middle of a sweep
        wr_en4 = 1'b1; wr_addr4 = 4'hF; wr_data4 = 64'h77;
        tick();
        wr_en4 = 1'b0;
        rd_en4 = 1'b1; rd_addr4 = 4'hF; rd_ready4 = 1'b0; clear_req4 = 1'b1;
        tick();
        chk("b4_pre_data", rd_data4, 64'h77);
        chk("b4_busy_start", 64'(busy4), 64'h1);
        rd_en4 = 1'b0; clear_req4 = 1'b0;
        tick();
        tick();
        chk("b4_pending_valid", 64'(rd_valid4), 64'h1);
        chk("b4_mid_busy", 64'(busy4), 64'h1);
        rst_n4 = 1'b0;
        #1;
        chk("b4_rst_busy", 64'(busy4), 64'h0);
        chk("b4_rst_valid", 64'(rd_valid4), 64'h0);
        #1;
        rst_n4 = 1'b1;
        rd_ready4 = 1'b1; rd_en4 = 1'b1; rd_addr4 = 4'hF;
        tick();
        chk("b4_post_valid", 64'(rd_valid4), 64'h1);
        chk("b4_post_uninit", 64'(rd_uninit4), 64'h1);
        chk("b4_post_data", rd_data4, 64'h0);
        rd_en4 = 1'b0;
        clear_req4 = 1'b1;
        tick();
        clear_req4 = 1'b0;
        n = 0;
        while (busy4 && n < 20) begin
            n++;
            tick();
        end
        chk("b4_busy_cycles", 64'(n), 64'd5);
        chk("b4_end_valid", 64'(rd_valid4), 64'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
